// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell stepped over WIDTH bit pairs, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d, carry_q, carry_d;
  logic             fa_s, fa_c;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (cy_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          cy_d    = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New sum bit enters at the MSB so the LSB-first result lands aligned after WIDTH steps.
        res_d = WIDTH'({fa_s, res_q} >> 1);
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = fa_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_d;
          carry_d = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = cy_q ^ fa_c;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign carry = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: 8-bit and 1-bit instances against an arithmetic reference.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, carry;
  logic [W-1:0] sum;
  logic         start1 = 1'b0;
  logic         a1 = 1'b0;
  logic         b1 = 1'b0;
  logic         cin1 = 1'b0;
  logic         busy1, done1, carry1;
  logic [0:0]   sum1;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf, ovf1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .carry(carry)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf1)
`endif
  );

  // Launches one operation from the current cycle and waits (bounded) for done.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       output int lat, output int busy_n, output logic stable);
    logic [W-1:0] prev;
    prev  = sum;
    start = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0; busy_n = 0; stable = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (sum !== prev || carry !== 1'b0 && carry !== carry) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, sum, carry} !== '0) begin
      bad++; $display("FAIL reset_w8: got busy=%b done=%b sum=%h carry=%b want all 0", busy, done, sum, carry);
    end
    total++;
    if ({busy1, done1, sum1, carry1} !== 4'b0) begin
      bad++; $display("FAIL reset_w1: got busy=%b done=%b sum=%b carry=%b want all 0", busy1, done1, sum1, carry1);
    end
`ifdef SERIAL_ADD_OVF_EN
    total++;
    if ({ovf, ovf1} !== 2'b00) begin
      bad++; $display("FAIL reset_ovf: got %b%b want 00", ovf, ovf1);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input bit idle_after);
    logic [W:0] e;
    int lat, busy_n;
    logic stable;
    e = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    do_op(av, bv, cv, lat, busy_n, stable);
    total++;
    if (lat !== W || busy_n !== W) begin
      bad++; $display("FAIL %s_latency: got lat=%0d busy=%0d want %0d", name, lat, busy_n, W);
    end
    total++;
    if (sum !== e[W-1:0] || carry !== e[W]) begin
      bad++; $display("FAIL %s_result: a=%h b=%h cin=%b got sum=%h carry=%b want sum=%h carry=%b",
                      name, av, bv, cv, sum, carry, e[W-1:0], e[W]);
    end
    total++;
    if (!stable) begin
      bad++; $display("FAIL %s_sum_held: got sum change during RUN want none", name);
    end
`ifdef SERIAL_ADD_OVF_EN
    total++;
    if (ovf !== ((av[W-1] == bv[W-1]) && (e[W-1] != av[W-1]))) begin
      bad++; $display("FAIL %s_ovf: a=%h b=%h got %b want %b", name, av, bv, ovf,
                      (av[W-1] == bv[W-1]) && (e[W-1] != av[W-1]));
    end
`endif
    if (idle_after) begin
      @(posedge clk); #1;
      total++;
      if ({busy, done} !== 2'b00) begin
        bad++; $display("FAIL %s_done_pulse: got busy=%b done=%b want 0 0", name, busy, done);
      end
    end
  endtask

  task automatic test_directed();
    check_op("zero",  8'h00, 8'h00, 1'b0, 1'b1);
    check_op("ff_01", 8'hFF, 8'h01, 1'b0, 1'b1);
    check_op("a5_5a", 8'hA5, 8'h5A, 1'b1, 1'b1);
    check_op("3c_0f", 8'h3C, 8'h0F, 1'b0, 1'b1);
    check_op("7f_01", 8'h7F, 8'h01, 1'b0, 1'b1);
    check_op("ff_01b", 8'hFF, 8'h01, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      check_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    if (done) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    int n_done, first;
    logic [W-1:0] s;
    logic c;
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0; first = -1; s = '0; c = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        n_done++;
        if (first < 0) begin first = i; s = sum; c = carry; end
      end
      @(posedge clk); #1;
    end
    total++;
    if (n_done !== 1 || first !== 5) begin
      bad++; $display("FAIL ignore_start_done: got count=%0d at=%0d want 1 at 5", n_done, first);
    end
    total++;
    if (s !== 8'h30 || c !== 1'b0) begin
      bad++; $display("FAIL ignore_start_result: got sum=%h carry=%b want 30 0", s, c);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    check_op("b2b_first", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({busy, done} !== 2'b10) begin
      bad++; $display("FAIL b2b_reentry: got busy=%b done=%b want 1 0", busy, done);
    end
    gap = 1;
    while (!done && gap < 40) begin
      @(posedge clk); #1;
      gap++;
    end
    total++;
    if (gap !== W + 1 || sum !== 8'h02 || carry !== 1'b0) begin
      bad++; $display("FAIL b2b_second: got gap=%0d sum=%h carry=%b want 9 02 0", gap, sum, carry);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int n_done;
    start = 1'b1; a = 8'h55; b = 8'h11; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, sum, carry} !== '0) begin
      bad++; $display("FAIL mid_reset_clear: got busy=%b done=%b sum=%h carry=%b want all 0", busy, done, sum, carry);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) n_done++;
      @(posedge clk); #1;
    end
    total++;
    if (n_done !== 0) begin
      bad++; $display("FAIL mid_reset_no_done: got %0d active cycles want 0", n_done);
    end
    check_op("post_reset", 8'h80, 8'h80, 1'b0, 1'b1);
  endtask

  task automatic test_width1();
    logic [1:0] e;
    logic av, bv, cv;
    for (int i = 0; i < 8; i++) begin
      {av, bv, cv} = 3'(i ^ 5);
      e = {1'b0, av} + {1'b0, bv} + {1'b0, cv};
      start1 = 1'b1; a1 = av; b1 = bv; cin1 = cv;
      @(posedge clk); #1;
      start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
      total++;
      if ({busy1, done1} !== 2'b10) begin
        bad++; $display("FAIL w1_run: got busy=%b done=%b want 1 0", busy1, done1);
      end
      @(posedge clk); #1;
      total++;
      if (done1 !== 1'b1 || sum1 !== e[0] || carry1 !== e[1]) begin
        bad++; $display("FAIL w1_result: a=%b b=%b cin=%b got done=%b sum=%b carry=%b want 1 %b %b",
                        av, bv, cv, done1, sum1, carry1, e[0], e[1]);
      end
`ifdef SERIAL_ADD_OVF_EN
      total++;
      if (ovf1 !== ((av == bv) && (e[0] != av))) begin
        bad++; $display("FAIL w1_ovf: got %b want %b", ovf1, (av == bv) && (e[0] != av));
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_width1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
